// File: rtl/four_to_one_mux_pkg.sv
// Shared widths and types for the four_to_one_mux slice.
package four_to_one_mux_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned EN_W  = 4;

  // Binary select formed as {s2,s1}
  typedef logic [SEL_W-1:0] sel_t;

  // One-hot source enable: bit0=a, bit1=b, bit2=c, bit3=d
  typedef logic [EN_W-1:0] en_t;

endpackage : four_to_one_mux_pkg

// File: rtl/four_to_one_mux_if.sv
// Select/data/output bundle of the 4:1 mux.
interface four_to_one_mux_if #(
  parameter int unsigned WIDTH = 1
);

  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] s3;

  // Source side drives select and data, observes the result
  modport master (
    output s1, s2, a, b, c, d,
    input  s3
  );

  // Mux side consumes select and data, drives the result
  modport slave (
    input  s1, s2, a, b, c, d,
    output s3
  );

endinterface : four_to_one_mux_if

// File: rtl/four_to_one_mux_sel_dec.sv
// Decodes the 2-bit select {s2,s1} into a one-hot source enable.
module four_to_one_sel_dec
  import four_to_one_mux_pkg::*;
(
  input  logic s1,
  input  logic s2,
  output en_t  en_c
);

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  sel_t sel;

  assign sel = {s2, s1};

  // Full case; unknown selects fall back to source a so no latch is inferred
  always_comb begin
    en_c = EN_W'(1);
    case (sel)
      SEL_A:   en_c = EN_W'(4'b0001);
      SEL_B:   en_c = EN_W'(4'b0010);
      SEL_C:   en_c = EN_W'(4'b0100);
      SEL_D:   en_c = EN_W'(4'b1000);
      default: en_c = EN_W'(4'b0001);
    endcase
  end

endmodule : four_to_one_sel_dec

// File: rtl/four_to_one_mux.sv
// 4:1 bitwise data mux with optional registered output stage.
module four_to_one_mux
  import four_to_one_mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  four_to_one_mux_if.slave     bus
);

  en_t              en_c;
  logic [WIDTH-1:0] mux_c;

  // One-hot enable from the select pair
  four_to_one_sel_dec u_sel_dec (
    .s1   (bus.s1),
    .s2   (bus.s2),
    .en_c (en_c)
  );

  // AND-OR datapath, applied per bit
  always_comb begin
    mux_c = ({WIDTH{en_c[0]}} & bus.a)
          | ({WIDTH{en_c[1]}} & bus.b)
          | ({WIDTH{en_c[2]}} & bus.c)
          | ({WIDTH{en_c[3]}} & bus.d);
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s3_d;
    logic [WIDTH-1:0] s3_q;

    // Next output value is the live mux result; no enable
    always_comb begin
      s3_d = mux_c;
    end

    // Output register; async reset clears any pending value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_q <= '0;
      end else begin
        s3_q <= s3_d;
      end
    end

    assign bus.s3 = s3_q;
  end else begin : g_comb
    // Clock and reset have no role in the combinational build
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst_n};

    assign bus.s3 = mux_c;
  end

endmodule : four_to_one_mux

// File: tb/tb_four_to_one_mux.sv
// Self-checking bench: combinational WIDTH=1 build and registered WIDTH=8 build.
module tb_four_to_one_mux;

  logic clk;
  logic rst_n;

  int unsigned n_vec;
  int unsigned n_err;

  four_to_one_mux_if #(.WIDTH(1)) if_c ();
  four_to_one_mux_if #(.WIDTH(8)) if_r ();

  four_to_one_mux #(.WIDTH(1), .REG_OUT(1'b0)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c.slave)
  );

  four_to_one_mux #(.WIDTH(8), .REG_OUT(1'b1)) u_dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the source whose index equals the select value
  function automatic logic [7:0] ref_mux(input logic [1:0] sel,
                                         input logic [7:0] av, input logic [7:0] bv,
                                         input logic [7:0] cv, input logic [7:0] dv);
    logic [7:0] src [4];
    src[0] = av;
    src[1] = bv;
    src[2] = cv;
    src[3] = dv;
    return src[sel];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive the combinational instance, settle 100 ns, compare
  task automatic apply_c(input string tag, input logic s2v, input logic s1v,
                         input logic av, input logic bv, input logic cv, input logic dv,
                         input logic expv);
    if_c.s2 = s2v;
    if_c.s1 = s1v;
    if_c.a  = av;
    if_c.b  = bv;
    if_c.c  = cv;
    if_c.d  = dv;
    #100;
    chk(tag, 8'(if_c.s3), 8'(expv));
  endtask

  task automatic drive_r(input logic [1:0] sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] cv, input logic [7:0] dv);
    {if_r.s2, if_r.s1} = sel;
    if_r.a = av;
    if_r.b = bv;
    if_r.c = cv;
    if_r.d = dv;
  endtask

  initial begin
    logic [5:0] v;
    logic [1:0] sel;
    logic [7:0] ra, rb, rc, rd, exp_r;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_r(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    // Registered build holds zero under reset
    @(posedge clk); #1;
    chk("t6_rst_hold", if_r.s3, 8'h00);

    // T1..T4 directed, combinational build
    apply_c("t1_a1",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_c("t1_a0",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_c("t2_b0",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_c("t2_b1",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    apply_c("t2_b0_a1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_c("t3_c1",    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_c("t3_c0",    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_c("t4_d1",    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    apply_c("t4_d0",    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_c("t4_ones",  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Select and data change together: new source's new value wins
    apply_c("simul_chg", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // T5 exhaustive sweep of {s2,s1,a,b,c,d}
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      {if_c.s2, if_c.s1, if_c.a, if_c.b, if_c.c, if_c.d} = v;
      #100;
      chk("t5_sweep", 8'(if_c.s3),
          ref_mux(v[5:4], 8'(v[3]), 8'(v[2]), 8'(v[1]), 8'(v[0])));
    end

    // T6 registered build: release reset, select c=A5
    @(negedge clk);
    chk("t6_rst_low", if_r.s3, 8'h00);
    rst_n = 1'b1;
    drive_r(2'b10, 8'h11, 8'h22, 8'hA5, 8'h44);
    #1;
    chk("t6_not_before", if_r.s3, 8'h00);
    @(posedge clk); #1;
    chk("t6_a5", if_r.s3, 8'hA5);

    // Random traffic, one-cycle latency
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      sel = 2'($urandom_range(3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rd = 8'($urandom);
      drive_r(sel, ra, rb, rc, rd);
      exp_r = ref_mux(sel, ra, rb, rc, rd);
      @(posedge clk); #1;
      chk("t6_rand", if_r.s3, exp_r);
    end

    // Mid-operation async reset between edges
    @(negedge clk);
    drive_r(2'b11, 8'h01, 8'h02, 8'h03, 8'h3C);
    @(posedge clk); #1;
    chk("t6_pre_rst", if_r.s3, 8'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", if_r.s3, 8'h00);
    @(posedge clk); #1;
    chk("t6_rst_hold2", if_r.s3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive_r(2'b01, 8'h00, 8'h5A, 8'h00, 8'h00);
    #1;
    chk("t6_discard", if_r.s3, 8'h00);
    @(posedge clk); #1;
    chk("t6_after_rst", if_r.s3, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_four_to_one_mux
